// File: rtl/cpu_dbg_defs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_dbg_defs : run-state encoding and default widths for the cpu run     |
// | controller, its cpu top and benches.  Revision 1.0                       |
// +--------------------------------------------------------------------------+
package cpu_dbg_defs;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_CNT_W = 32;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_RST_HOLD = 2'd1;
  localparam logic [1:0] ST_RUN      = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

endpackage
`default_nettype wire

// File: rtl/cpu_run_controller_pc_trace_ring.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_trace_ring : ring buffer of recent PCs with saturating entry count    |
// | and combinational newest-first indexed read.  Revision 1.0               |
// +--------------------------------------------------------------------------+
module pc_trace_ring
  import cpu_dbg_defs::*;
#(
  parameter int unsigned XLEN        = DEF_XLEN,
  parameter int unsigned TRACE_DEPTH = 16,
  localparam int unsigned TR_AW      = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              wr_en,
  input  logic [XLEN-1:0]   wr_pc,
  input  logic [TR_AW-1:0]  rd_idx,
  output logic [XLEN-1:0]   rd_pc,
  output logic [TR_AW:0]    count
);

  logic [XLEN-1:0]  mem_q [TRACE_DEPTH];
  logic [TR_AW-1:0] wptr_q, wptr_d;
  logic [TR_AW:0]   count_q, count_d;
  logic [TR_AW-1:0] rd_addr;

  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (wr_en) begin
      wptr_d = wptr_q + TR_AW'(1);
      if (count_q != (TR_AW+1)'(TRACE_DEPTH)) begin
        count_d = count_q + (TR_AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; entries beyond count are never exposed.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q] <= wr_pc;
    end
  end

  assign rd_addr = wptr_q - TR_AW'(1) - rd_idx;
  assign rd_pc   = ({1'b0, rd_idx} < count_q) ? mem_q[rd_addr] : '0;
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/cpu_run_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | cpu_run_controller : sequences cpu reset, counts RUN cycles, detects     |
// | PC self-loop halt or timeout, keeps a PC trace.  Revision 1.0            |
// +--------------------------------------------------------------------------+
module cpu_run_controller
  import cpu_dbg_defs::*;
#(
  parameter int unsigned XLEN         = DEF_XLEN,
  parameter int unsigned CNT_W        = DEF_CNT_W,
  parameter int unsigned RESET_CYCLES = 4,
  parameter int unsigned HALT_REPEAT  = 8,
  parameter int unsigned MAX_CYCLES   = 100000,
  parameter int unsigned TRACE_DEPTH  = 16,
  localparam int unsigned TR_AW       = $clog2(TRACE_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [XLEN-1:0]   pc_in,
  output logic              cpu_reset,
  output logic              running,
  output logic              done,
  output logic              halted,
  output logic              timeout,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [TR_AW:0]    trace_count,
  input  logic [TR_AW-1:0]  trace_idx,
  output logic [XLEN-1:0]   trace_pc
);

  localparam int unsigned RST_W = $clog2(RESET_CYCLES + 1);
  localparam int unsigned RPT_W = $clog2(HALT_REPEAT);

  logic [1:0]       state_q, state_d;
  logic [RST_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic [XLEN-1:0]  last_pc_q, last_pc_d;
  logic             halted_q, halted_d;
  logic             timeout_q, timeout_d;

  logic             first_run;
  logic             pc_same;
  logic [CNT_W-1:0] cnt_inc;
  logic [RPT_W-1:0] rpt_next;
  logic             trace_clr;
  logic             trace_we;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    rpt_d     = rpt_q;
    last_pc_d = last_pc_q;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    trace_clr = 1'b0;
    trace_we  = 1'b0;
    // A zero cycle count in RUN marks the first cycle, which has no previous PC.
    first_run = (cnt_q == '0);
    pc_same   = (pc_in == last_pc_q);
    cnt_inc   = cnt_q + CNT_W'(1);
    rpt_next  = (first_run || !pc_same) ? '0 : rpt_q + RPT_W'(1);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d   = ST_RST_HOLD;
          hold_d    = '0;
          cnt_d     = '0;
          rpt_d     = '0;
          halted_d  = 1'b0;
          timeout_d = 1'b0;
          trace_clr = 1'b1;
        end
      end
      ST_RST_HOLD: begin
        if (hold_q == RST_W'(RESET_CYCLES - 1)) begin
          state_d = ST_RUN;
        end else begin
          hold_d = hold_q + RST_W'(1);
        end
      end
      ST_RUN: begin
        cnt_d     = cnt_inc;
        rpt_d     = rpt_next;
        last_pc_d = pc_in;
        trace_we  = first_run || !pc_same;
        // Halt takes priority when both conditions land on the same cycle.
        if (rpt_next == RPT_W'(HALT_REPEAT - 1)) begin
          state_d  = ST_DONE;
          halted_d = 1'b1;
        end else if (cnt_inc == CNT_W'(MAX_CYCLES)) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= '0;
      cnt_q     <= '0;
      rpt_q     <= '0;
      last_pc_q <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      cnt_q     <= cnt_d;
      rpt_q     <= rpt_d;
      last_pc_q <= last_pc_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
    end
  end

  pc_trace_ring #(
    .XLEN        (XLEN),
    .TRACE_DEPTH (TRACE_DEPTH)
  ) u_trace (
    .clk    (clk),
    .reset  (reset),
    .clr    (trace_clr),
    .wr_en  (trace_we),
    .wr_pc  (pc_in),
    .rd_idx (trace_idx),
    .rd_pc  (trace_pc),
    .count  (trace_count)
  );

  assign cpu_reset   = (state_q == ST_IDLE) || (state_q == ST_RST_HOLD);
  assign running     = (state_q == ST_RUN);
  assign done        = (state_q == ST_DONE);
  assign halted      = halted_q;
  assign timeout     = timeout_q;
  assign cycle_count = cnt_q;

endmodule
`default_nettype wire
